// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider with signed/unsigned operation and
// RISC-V divide-by-zero / signed-overflow results. One quotient bit per cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] remainder_q;
    logic [CW-1:0]    cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;

    logic             a_neg_d;
    logic             b_neg_d;
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;
    logic             div_zero_d;
    logic             ovf_d;

    logic [WIDTH:0]   shifted_d;
    logic [WIDTH:0]   diff_d;
    logic             qbit_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] q_fix_d;
    logic [WIDTH-1:0] r_fix_d;

    // Launch decode: operand magnitudes and special-case detection.
    always_comb begin
        a_neg_d    = is_signed & a[WIDTH-1];
        b_neg_d    = is_signed & b[WIDTH-1];
        mag_a_d    = a_neg_d ? (~a + WIDTH'(1)) : a;
        mag_b_d    = b_neg_d ? (~b + WIDTH'(1)) : b;
        div_zero_d = (b == '0);
        ovf_d      = is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    end

    // One restoring step; the quotient shifts into the vacated dividend bits.
    always_comb begin
        shifted_d = {rem_q, dvd_q[WIDTH-1]};
        diff_d    = shifted_d - {1'b0, dvs_q};
        qbit_d    = (shifted_d >= {1'b0, dvs_q});
        if (qbit_d) begin
            rem_d = diff_d[WIDTH-1:0];
        end else begin
            rem_d = shifted_d[WIDTH-1:0];
        end
        dvd_d   = {dvd_q[WIDTH-2:0], qbit_d};
        q_fix_d = q_neg_q ? (~dvd_d + WIDTH'(1)) : dvd_d;
        r_fix_d = r_neg_q ? (~rem_d + WIDTH'(1)) : rem_d;
    end

    // Stall request: running, or a launch happening this cycle.
    always_comb begin
        if (!reset_n) begin
            busy = 1'b0;
        end else begin
            busy = (state_q == RUN) | start;
        end
    end

    // Divider state machine and result registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        q_neg_q <= a_neg_d ^ b_neg_d;
                        r_neg_q <= a_neg_d;
                        cnt_q   <= '0;
                        if (div_zero_d) begin
                            result_q    <= '1;
                            remainder_q <= a;
                            state_q     <= DONE;
                        end else if (ovf_d) begin
                            result_q    <= a;
                            remainder_q <= '0;
                            state_q     <= DONE;
                        end else begin
                            dvd_q   <= mag_a_d;
                            dvs_q   <= mag_b_d;
                            rem_q   <= '0;
                            state_q <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_q       <= '0;
                        result_q    <= q_fix_d;
                        remainder_q <= r_fix_d;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes expected quotient, remainder
// and busy length per launch; a monitor checks busy/hold/completion every cycle.
module tb_div_unit;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rem;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] result;
    logic [31:0] remainder;
    logic        busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    div_unit #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .result    (result),
        .remainder (remainder),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour from plain arithmetic (SV / and % truncate toward zero).
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic s);
        exp_t e;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = av;
        sb = bv;
        if (bv == 32'd0) begin
            e.res = 32'hFFFF_FFFF; e.rem = av; e.lat = 1;
        end else if (s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            e.res = av; e.rem = 32'd0; e.lat = 1;
        end else if (s) begin
            e.res = sa / sb; e.rem = sa % sb; e.lat = 33;
        end else begin
            e.res = av / bv; e.rem = av % bv; e.lat = 33;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Launch in the current cycle; returns in that op's DONE cycle with start still high.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic s);
        exp_t e;
        start = 1'b1; a = av; b = bv; is_signed = s;
        e = model(av, bv, s);
        exp_q.push_back(e);
        for (int i = 0; i < e.lat; i++) begin
            step();
            if (i < e.lat - 1) begin
                a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) step();
    endtask

    // Monitor: busy profile, output hold during an op, result at completion.
    initial begin
        bit          active = 1'b0;
        bit          rst_prev = 1'b0;
        int          k = 0;
        exp_t        cur;
        logic [31:0] hr = 32'd0;
        logic [31:0] hm = 32'd0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                chk("busy_in_reset", {31'd0, busy}, 32'd0);
                if (rst_prev) begin
                    chk("result_after_reset", result, 32'd0);
                    chk("remainder_after_reset", remainder, 32'd0);
                end
                rst_prev = 1'b1;
                active = 1'b0;
                hr = 32'd0;
                hm = 32'd0;
            end else begin
                rst_prev = 1'b0;
                if (active && k == cur.lat) begin
                    chk("result", result, cur.res);
                    chk("remainder", remainder, cur.rem);
                    hr = cur.res;
                    hm = cur.rem;
                    active = 1'b0;
                end
                if (!active && exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    active = 1'b1;
                    k = 0;
                end
                if (active) begin
                    chk("busy_during_op", {31'd0, busy}, 32'd1);
                    chk("result_hold", result, hr);
                    chk("remainder_hold", remainder, hm);
                    k++;
                end else begin
                    chk("busy_idle", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Driver: directed cases from the plan, then randomized operands.
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        repeat (3) step();
        reset_n = 1'b1;
        idle(2);

        do_op(32'd100, 32'd7, 1'b0);                  idle(2);
        do_op(-32'sd7, 32'd2, 1'b1);                  idle(1);
        do_op(32'd7, -32'sd2, 1'b1);                  idle(1);
        do_op(-32'sd7, -32'sd2, 1'b1);                idle(1);
        do_op(32'h1234_5678, 32'd0, 1'b0);            idle(1);
        do_op(32'h1234_5678, 32'd0, 1'b1);            idle(1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);    idle(1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);    idle(1);

        // Back-to-back: operands switched in the DONE cycle.
        do_op(32'd100, 32'd7, 1'b0);
        do_op(32'd50, 32'd5, 1'b0);
        idle(2);

        // Reset in cycle 10 of a running op.
        start = 1'b1; a = 32'hDEAD_BEEF; b = 32'd3; is_signed = 1'b0;
        exp_q.push_back(model(a, b, is_signed));
        repeat (10) step();
        reset_n = 1'b0;
        start = 1'b0;
        exp_q.delete();
        repeat (2) step();
        reset_n = 1'b1;
        step();
        do_op(32'd9, 32'd4, 1'b0);                    idle(2);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            ra = $urandom;
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) rb = 32'hFFFF_FFFF;
            else if (sel < 5) rb = $urandom_range(1, 20);
            else rb = $urandom;
            if (sel == 1 && ($urandom_range(0, 1) == 1)) ra = 32'h8000_0000;
            do_op(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(4);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 restoring divider, the multi-cycle unit that computes quotient and remainder for the ALU's DIV/DIVU/REM/REMU ops. The ALU holds `start` high for as long as a divide op sits in execute. It stalls the pipeline on `busy` and selects `result` or `remainder` by op. This unit adds signed/unsigned control and RISC-V special-case results.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.

Ports:
- `clock`  in  1  single clock, all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level request; high while a divide op is in execute.
- `is_signed`  in  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU.
- `a`  in  WIDTH  dividend.
- `b`  in  WIDTH  divisor.
- `result`  out  WIDTH  quotient, registered.
- `remainder`  out  WIDTH  remainder, registered.
- `busy`  out  1  stall request to the pipeline.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=0: stay.
  - `start`=1: latch |a|, |b| magnitudes (signed mode) or raw values, quotient sign = sign(a) XOR sign(b), remainder sign = sign(a), iteration counter = 0.
  - Special case at launch: go to DONE directly, writing outputs.
  - Otherwise: go to RUN.
- RUN:
  - One restoring step per cycle: shift partial remainder left by 1, bringing in next dividend MSB.
  - If partial remainder ≥ divisor: subtract, quotient bit = 1.
  - After WIDTH steps: write `result`/`remainder` with sign fixup applied (negate quotient if signs differ; negate remainder if dividend negative; signed mode only), then go to DONE.
- DONE: lasts exactly one cycle. In DONE, `start` is treated exactly as in IDLE (a high `start` launches a new op from the current `a`/`b`/`is_signed`); this supports back-to-back divides because the pipeline advances during the DONE cycle.
- Special cases (both complete with no RUN cycles):
  - `b`=0, either mode: `result` = all ones, `remainder` = `a`.
  - Signed, `a` = most-negative, `b` = −1: `result` = `a`, `remainder` = 0.
- Operands:
  - `a`, `b`, `is_signed` are sampled only at launch; changes during RUN are ignored.
  - Unsigned magnitude of most-negative value (2^(WIDTH−1)) fits in WIDTH bits; no widening beyond WIDTH+1-bit partial remainder.
- `busy` is combinational:
  - 1 in RUN.
  - 1 in IDLE or DONE when `start`=1 and a launch occurs this cycle.
  - 0 otherwise, and 0 whenever `reset_n`=0.
- `result`/`remainder` hold their last written value until the next completion.

## Timing
- Reset (`reset_n` low at an edge): state=IDLE, `result`=0, `remainder`=0, counter=0.
  - Reset mid-RUN abandons the op; outputs go to 0.
  - `busy` is 0 in every cycle `reset_n` is low.
- Normal op, launch cycle = cycle 0:
  - `busy`=1 in cycles 0..WIDTH (33 cycles for WIDTH=32).
  - Outputs written at end of cycle WIDTH; DONE in cycle WIDTH+1 with `busy`=0 and outputs valid.
- Special case:
  - `busy`=1 in cycle 0 only.
  - Outputs valid in cycle 1 (DONE, `busy`=0).
- Back-to-back: with `start` high in DONE, the next op's cycle 0 is that DONE cycle, so `busy` stays low for no cycle between ops except that DONE's combinational launch raises it. Result of the prior op is visible in that cycle's outputs before the edge.
- No output changes except at completion or reset.

## Test plan
- Unsigned: a=100, b=7, `is_signed`=0, `start` held → `busy` high exactly 33 cycles; then `result`=14, `remainder`=2 with `busy`=0.
- Signed sign rules:
  - a=−7, b=2 → `result`=0xFFFFFFFD, `remainder`=0xFFFFFFFF.
  - a=7, b=−2 → `result`=0xFFFFFFFD, `remainder`=1.
  - a=−7, b=−2 → `result`=3, `remainder`=0xFFFFFFFF.
- Divide by zero: a=0x12345678, b=0, in both modes → `busy` high 1 cycle; `result`=0xFFFFFFFF, `remainder`=0x12345678.
- Overflow:
  - a=0x80000000, b=0xFFFFFFFF, signed → 1 busy cycle; `result`=0x80000000, `remainder`=0.
  - Same operands unsigned → 33 busy cycles; `result`=0, `remainder`=0x80000000.
- Back-to-back: `start` held high, operands switched from (100,7) to (50,5) in the DONE cycle → second op completes 33 cycles later with `result`=10, `remainder`=0. First op's outputs (14,2) are visible throughout the second op's RUN.
- Reset mid-op: `reset_n` low at cycle 10 of a run → `busy`=0 and outputs=0 next cycle. After release, a=9, b=4 unsigned → `result`=2, `remainder`=1 after 33 busy cycles.
